// File: rtl/data_mem_stage_if.sv
// Bus between the EX/MEM pipeline register and the data memory stage.
// The master side drives the access; the slave side returns load data, faults and the store record.
interface data_mem_stage_if;
    logic [31:0] pc_in;
    logic [3:0]  mem_op;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] mem_read_data;
    logic        adel;
    logic        ades;
    logic        st_valid;
    logic [31:0] st_pc;
    logic [31:0] st_addr;
    logic [31:0] st_data;

    modport master (
        output pc_in, mem_op, addr, wdata,
        input  mem_read_data, adel, ades, st_valid, st_pc, st_addr, st_data
    );

    modport slave (
        input  pc_in, mem_op, addr, wdata,
        output mem_read_data, adel, ades, st_valid, st_pc, st_addr, st_data
    );
endinterface

// File: rtl/data_mem_stage.sv
// MEM-stage data memory: combinational extended loads, merged word/half/byte stores,
// address-error flags and a registered record of every committed store.
module data_mem_stage #(
    parameter int          DEPTH_WORDS = 4096,
    parameter logic [31:0] ADDR_BASE   = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            reset,
    data_mem_stage_if.slave bus
);
    localparam int          IDX_W      = $clog2(DEPTH_WORDS);
    localparam logic [32:0] ADDR_LIMIT = {1'b0, ADDR_BASE} + 33'(DEPTH_WORDS) * 33'd4;

    typedef enum logic [3:0] {
        OP_NONE = 4'd0,
        OP_LW   = 4'd1,
        OP_LH   = 4'd2,
        OP_LHU  = 4'd3,
        OP_LB   = 4'd4,
        OP_LBU  = 4'd5,
        OP_SW   = 4'd6,
        OP_SH   = 4'd7,
        OP_SB   = 4'd8
    } mem_op_e;

    logic [IDX_W-1:0] word_idx;
    logic             in_range;
    logic             is_load;
    logic             is_store;
    logic             misaligned;
    logic             adel;
    logic             ades;
    logic             commit;
    logic [31:0]      rd_word;
    logic [15:0]      rd_half;
    logic [7:0]       rd_byte;
    logic [31:0]      load_data;
    logic [31:0]      merged;
    logic [31:0]      mem_words [DEPTH_WORDS];
    logic             st_valid_q;
    logic [31:0]      st_pc_q;
    logic [31:0]      st_addr_q;
    logic [31:0]      st_data_q;

    // 33-bit compare so an address near the top of the space cannot wrap into range.
    assign word_idx = IDX_W'((bus.addr - ADDR_BASE) >> 2);
    assign in_range = ({1'b0, bus.addr} >= {1'b0, ADDR_BASE}) && ({1'b0, bus.addr} < ADDR_LIMIT);

    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        is_load    = 1'b0;
        is_store   = 1'b0;
        misaligned = 1'b0;
        case (bus.mem_op)
            OP_LW:         begin is_load  = 1'b1; misaligned = |bus.addr[1:0]; end
            OP_LH, OP_LHU: begin is_load  = 1'b1; misaligned = bus.addr[0];    end
            OP_LB, OP_LBU:       is_load  = 1'b1;
            OP_SW:         begin is_store = 1'b1; misaligned = |bus.addr[1:0]; end
            OP_SH:         begin is_store = 1'b1; misaligned = bus.addr[0];    end
            OP_SB:               is_store = 1'b1;
            default:       ;
        endcase
    end

    assign adel    = is_load  && (misaligned || !in_range);
    assign ades    = is_store && (misaligned || !in_range);
    assign commit  = is_store && !ades;
    assign rd_word = mem_words[word_idx];

    always_comb begin
        rd_half   = bus.addr[1] ? rd_word[31:16] : rd_word[15:0];
        rd_byte   = rd_word[{bus.addr[1:0], 3'b000} +: 8];
        load_data = '0;
        if (!adel) begin
            case (bus.mem_op)
                OP_LW:   load_data = rd_word;
                OP_LH:   load_data = {{16{rd_half[15]}}, rd_half};
                OP_LHU:  load_data = {16'h0000, rd_half};
                OP_LB:   load_data = {{24{rd_byte[7]}}, rd_byte};
                OP_LBU:  load_data = {24'h00_0000, rd_byte};
                default: load_data = '0;
            endcase
        end
    end

    always_comb begin
        merged = rd_word;
        case (bus.mem_op)
            OP_SW: merged = bus.wdata;
            OP_SH: begin
                if (bus.addr[1]) merged[31:16] = bus.wdata[15:0];
                else             merged[15:0]  = bus.wdata[15:0];
            end
            OP_SB:   merged[{bus.addr[1:0], 3'b000} +: 8] = bus.wdata[7:0];
            default: ;
        endcase
    end

    // NOTE: the array is built from flops, one per word, so a single reset edge can clear all of it;
    // a RAM macro could not be zeroed this way.
    for (genvar g = 0; g < DEPTH_WORDS; g++) begin : g_word
        logic [31:0] word_q;
        always_ff @(posedge clk) begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
            if (reset)                                 word_q <= '0;
            else if (commit && word_idx == IDX_W'(g)) word_q <= merged;
        end
        assign mem_words[g] = word_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            st_valid_q <= 1'b0;
            st_pc_q    <= '0;
            st_addr_q  <= '0;
            st_data_q  <= '0;
        end else begin
            st_valid_q <= commit;
            if (commit) begin
                st_pc_q   <= bus.pc_in;
                st_addr_q <= {bus.addr[31:2], 2'b00};
                st_data_q <= merged;
            end
        end
    end

    assign bus.mem_read_data = load_data;
    assign bus.adel          = adel;
    assign bus.ades          = ades;
    assign bus.st_valid      = st_valid_q;
    assign bus.st_pc         = st_pc_q;
    assign bus.st_addr       = st_addr_q;
    assign bus.st_data       = st_data_q;
endmodule

// File: tb/tb_data_mem_stage.sv
// Directed bench for data_mem_stage: each vector queues its hand-computed response,
// and a negedge monitor pops and compares whatever the DUT presents in that cycle.
module tb_data_mem_stage;
    localparam logic [3:0] NONE = 4'd0, LW = 4'd1, LH = 4'd2, LHU = 4'd3, LB = 4'd4,
                           LBU = 4'd5, SW = 4'd6, SH = 4'd7, SB = 4'd8, BAD = 4'd9;

    typedef struct {
        int          idx;
        logic [31:0] rd;
        logic        adel;
        logic        ades;
        logic        st_valid;
        logic [31:0] st_pc;
        logic [31:0] st_addr;
        logic [31:0] st_data;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;
    int   vec_n  = 0;
    exp_t exp_q[$];

    data_mem_stage_if bus ();

    data_mem_stage dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %08h, expected %08h", name, actual, expected);
        end
    endtask

    // Drive one cycle of stimulus and queue the response expected during that cycle.
    task automatic apply(input logic rst, input logic [3:0] op, input logic [31:0] a, input logic [31:0] wd,
                         input logic [31:0] pc, input logic [31:0] e_rd, input logic e_adel, input logic e_ades,
                         input logic e_stv, input logic [31:0] e_pc, input logic [31:0] e_addr,
                         input logic [31:0] e_data);
        exp_t e;
        reset      = rst;
        bus.mem_op = op;
        bus.addr   = a;
        bus.wdata  = wd;
        bus.pc_in  = pc;
        e.idx      = vec_n;
        e.rd       = e_rd;
        e.adel     = e_adel;
        e.ades     = e_ades;
        e.st_valid = e_stv;
        e.st_pc    = e_pc;
        e.st_addr  = e_addr;
        e.st_data  = e_data;
        exp_q.push_back(e);
        vec_n++;
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            exp_t e;
            e = exp_q.pop_front();
            check($sformatf("v%0d mem_read_data", e.idx), bus.mem_read_data, e.rd);
            check($sformatf("v%0d adel", e.idx), 32'(bus.adel), 32'(e.adel));
            check($sformatf("v%0d ades", e.idx), 32'(bus.ades), 32'(e.ades));
            check($sformatf("v%0d st_valid", e.idx), 32'(bus.st_valid), 32'(e.st_valid));
            check($sformatf("v%0d st_pc", e.idx), bus.st_pc, e.st_pc);
            check($sformatf("v%0d st_addr", e.idx), bus.st_addr, e.st_addr);
            check($sformatf("v%0d st_data", e.idx), bus.st_data, e.st_data);
        end
    end

    initial begin
        reset      = 1'b1;
        bus.mem_op = NONE;
        bus.addr   = '0;
        bus.wdata  = '0;
        bus.pc_in  = '0;
        repeat (2) @(posedge clk);
        #1;

        //     rst  op    addr          wdata         pc            rd            adel  ades  stv   st_pc     st_addr       st_data
        apply(1'b0, LW,   32'h0000_0010, 32'h0,        32'h100, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 32'h0,   32'h0,        32'h0);
        apply(1'b0, SW,   32'h0000_0010, 32'h8765_4321, 32'h104, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 32'h0,   32'h0,        32'h0);
        apply(1'b0, LB,   32'h0000_0013, 32'h0,        32'h108, 32'hFFFF_FF87, 1'b0, 1'b0, 1'b1, 32'h104, 32'h10,       32'h8765_4321);
        apply(1'b0, LBU,  32'h0000_0013, 32'h0,        32'h10C, 32'h0000_0087, 1'b0, 1'b0, 1'b0, 32'h104, 32'h10,       32'h8765_4321);
        apply(1'b0, LH,   32'h0000_0012, 32'h0,        32'h110, 32'hFFFF_8765, 1'b0, 1'b0, 1'b0, 32'h104, 32'h10,       32'h8765_4321);
        apply(1'b0, LHU,  32'h0000_0012, 32'h0,        32'h114, 32'h0000_8765, 1'b0, 1'b0, 1'b0, 32'h104, 32'h10,       32'h8765_4321);
        apply(1'b0, SB,   32'h0000_0011, 32'hFFFF_FFAB, 32'h118, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 32'h104, 32'h10,       32'h8765_4321);
        apply(1'b0, SH,   32'h0000_0012, 32'hCCCC_1234, 32'h11C, 32'h0000_0000, 1'b0, 1'b0, 1'b1, 32'h118, 32'h10,       32'h8765_AB21);
        apply(1'b0, LW,   32'h0000_0010, 32'h0,        32'h120, 32'h1234_AB21, 1'b0, 1'b0, 1'b1, 32'h11C, 32'h10,       32'h1234_AB21);
        apply(1'b0, SW,   32'h0000_0012, 32'h1111_1111, 32'h124, 32'h0000_0000, 1'b0, 1'b1, 1'b0, 32'h11C, 32'h10,       32'h1234_AB21);
        apply(1'b0, LH,   32'h0000_0011, 32'h0,        32'h128, 32'h0000_0000, 1'b1, 1'b0, 1'b0, 32'h11C, 32'h10,       32'h1234_AB21);
        apply(1'b0, LW,   32'h0000_0010, 32'h0,        32'h12C, 32'h1234_AB21, 1'b0, 1'b0, 1'b0, 32'h11C, 32'h10,       32'h1234_AB21);
        apply(1'b0, SW,   32'h0000_4000, 32'h5555_5555, 32'h130, 32'h0000_0000, 1'b0, 1'b1, 1'b0, 32'h11C, 32'h10,       32'h1234_AB21);
        apply(1'b0, LW,   32'hFFFF_FFFC, 32'h0,        32'h134, 32'h0000_0000, 1'b1, 1'b0, 1'b0, 32'h11C, 32'h10,       32'h1234_AB21);
        apply(1'b0, SW,   32'h0000_3FFC, 32'hA5A5_A5A5, 32'h138, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 32'h11C, 32'h10,       32'h1234_AB21);
        apply(1'b0, LW,   32'h0000_3FFC, 32'h0,        32'h13C, 32'hA5A5_A5A5, 1'b0, 1'b0, 1'b1, 32'h138, 32'h3FFC,     32'hA5A5_A5A5);
        apply(1'b0, LW,   32'h0000_0000, 32'h0,        32'h140, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 32'h138, 32'h3FFC,     32'hA5A5_A5A5);
        apply(1'b0, LB,   32'h0000_0011, 32'h0,        32'h144, 32'hFFFF_FFAB, 1'b0, 1'b0, 1'b0, 32'h138, 32'h3FFC,     32'hA5A5_A5A5);
        apply(1'b0, LBU,  32'h0000_0010, 32'h0,        32'h148, 32'h0000_0021, 1'b0, 1'b0, 1'b0, 32'h138, 32'h3FFC,     32'hA5A5_A5A5);
        apply(1'b0, LH,   32'h0000_0010, 32'h0,        32'h14C, 32'hFFFF_AB21, 1'b0, 1'b0, 1'b0, 32'h138, 32'h3FFC,     32'hA5A5_A5A5);
        apply(1'b0, LHU,  32'h0000_0010, 32'h0,        32'h150, 32'h0000_AB21, 1'b0, 1'b0, 1'b0, 32'h138, 32'h3FFC,     32'hA5A5_A5A5);
        apply(1'b0, BAD,  32'h0000_0010, 32'h0,        32'h154, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 32'h138, 32'h3FFC,     32'hA5A5_A5A5);
        apply(1'b1, SW,   32'h0000_0020, 32'hDEAD_BEEF, 32'h158, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 32'h138, 32'h3FFC,     32'hA5A5_A5A5);
        apply(1'b0, LW,   32'h0000_0020, 32'h0,        32'h15C, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 32'h0,   32'h0,        32'h0);
        apply(1'b0, LW,   32'h0000_0010, 32'h0,        32'h160, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 32'h0,   32'h0,        32'h0);
        apply(1'b0, LW,   32'h0000_3FFC, 32'h0,        32'h164, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 32'h0,   32'h0,        32'h0);

        bus.mem_op = NONE;
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk);
        check("scoreboard drained", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/data_mem_stage.md
# data_mem_stage

Data memory of the MEM stage in the 5-stage MIPS pipeline. It takes the byte address computed in EX and the store operand from the EX/MEM register, performs word/half/byte stores into a synchronous-write array, and returns sign- or zero-extended load data combinationally in the same cycle. The load data feeds the MEM/WB pipeline register's memory-read-data field. It also flags misaligned or out-of-range accesses and publishes a registered record of each committed store for the bench and trace logger.

## Interface
- DEPTH_WORDS, 4096: number of 32-bit words in the array; power of two.
- ADDR_BASE, 32'h0000_0000: byte address of word 0; word-aligned.
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  synchronous, active-high; clock clk.
- pc_in  in  32  PC of the instruction in MEM; used only for the store record.
- mem_op  in  4  0 none, 1 lw, 2 lh, 3 lhu, 4 lb, 5 lbu, 6 sw, 7 sh, 8 sb; 9–15 treated as none.
- addr  in  32  byte address (ALU result).
- wdata  in  32  store operand (rt value after forwarding).
- mem_read_data  out  32  extended load result; 0 when not a valid load.
- adel  out  1  load address error: misaligned or out of range.
- ades  out  1  store address error: misaligned or out of range.
- st_valid  out  1  registered: a store committed on the previous edge.
- st_pc  out  32  registered PC of that store.
- st_addr  out  32  registered word-aligned byte address of that store.
- st_data  out  32  registered full word held at st_addr after the store.

## Operation
- Word index = (addr − ADDR_BASE) >> 2; in range iff ADDR_BASE ≤ addr < ADDR_BASE + 4·DEPTH_WORDS, computed without wrap (33-bit compare).
- Alignment: lw/sw need addr[1:0]=0; lh/lhu/sh need addr[0]=0; byte ops always aligned.
- Error flags (combinational): adel = load op and (misaligned or out of range); ades = store op and (misaligned or out of range). Mutually exclusive.
- Loads: word w = array[index]; lw → w; lh/lhu select w[31:16] if addr[1] else w[15:0], sign/zero extend to 32; lb/lbu select byte addr[1:0] (0 = bits 7:0, little-endian), sign/zero extend. adel set → mem_read_data = 0. Non-load op → 0.
- Stores: merge into the current word: sw all 4 bytes; sh wdata[15:0] into halfword addr[1]; sb wdata[7:0] into byte addr[1:0]; untouched bytes unchanged. Suppressed entirely when ades or reset.
- Store record: on each edge st_valid ← committed; when committed, st_pc ← pc_in, st_addr ← {addr[31:2],2'b00}, st_data ← merged word; otherwise st_pc/st_addr/st_data hold.
- Reset: on a reset edge every array word ← 0, st_valid/st_pc/st_addr/st_data ← 0; a store presented that cycle is dropped.

## Timing
- Read path combinational: mem_read_data, adel, ades valid in the same cycle as inputs; reflect array contents before the coming edge.
- Write latency: store presented in cycle N is visible to a load in cycle N+1 (no same-cycle bypass needed; pipeline never has load and store in MEM together).
- Store record appears in cycle N+1 and st_valid drops in N+2 unless another store commits at edge N+1.
- Back-to-back stores to the same word each merge into the result of the previous one.
- Output reset values after the reset edge: mem_read_data 0 (array zero or op none), adel 0/ades 0 for op none, st_* all 0.
- Reset asserted mid-sequence: the in-flight store is discarded; the following cycle reads all-zero memory.

## Test plan
- Reset, then lw at 0x0000_0010 → mem_read_data 0, adel 0, st_valid 0.
- sw 0x8765_4321 at 0x10, next cycle lb/lbu at 0x13, lh/lhu at 0x12 → 0xFFFF_FF87 / 0x0000_0087 / 0xFFFF_8765 / 0x0000_8765; st_valid 1 one cycle, st_addr 0x10, st_data 0x8765_4321.
- After above, sb 0xAB at 0x11 then sh 0x1234 at 0x12 → lw 0x10 returns 0x1234_AB21; two consecutive st_valid cycles with st_data 0x8765_AB21 then 0x1234_AB21.
- sw at 0x12 and lh at 0x11 → ades 1 then adel 1, word 0x10 unchanged, mem_read_data 0, st_valid 0.
- sw at ADDR_BASE + 4·DEPTH_WORDS (0x4000 for defaults) and lw at 0xFFFF_FFFC → ades/adel 1, no write, read 0; sw at 0x3FFC succeeds.
- sw 0xDEAD_BEEF at 0x20 in the same cycle reset is high → next cycle lw 0x20 returns 0, st_valid 0.
